table_access_scheduler: RTL and testbench
=========================================

# table_access_scheduler

Sequences and shares the switch's ID/target lookup table between R lookup requesters and one update port. It drives a single internal write port and a single internal read port of an external combinational-read table. It also runs a sweep FSM that zeroes every entry after reset and on a flush request. Lookup results return on a registered response channel tagged with the requester index.

## Interface
- R, 4, number of lookup requesters (≥1)
- D, 16, table depth (≥2)
- WIDTH, 32, entry width
- LOG_D, (D>1)?$clog2(D):1, address width
- LOG_R, (R>1)?$clog2(R):1, requester index width

- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- lk_valid_i  input  R  lookup request valid per requester
- lk_ready_o  output  R  lookup accept, one-hot or zero
- lk_addr_i  input  R*LOG_D  lookup address; requester i at bits [i*LOG_D +: LOG_D]
- rsp_valid_o  output  1  lookup response valid, one-cycle pulse per accepted lookup
- rsp_idx_o  output  LOG_R  requester index of the response
- rsp_data_o  output  WIDTH  looked-up entry
- upd_valid_i  input  1  update request
- upd_ready_o  output  1  update accept
- upd_addr_i  input  LOG_D  update address
- upd_data_i  input  WIDTH  update data
- flush_i  input  1  start a zeroing sweep (level, sampled in RUN)
- busy_o  output  1  sweep in progress
- ram_we_o  output  1  table write enable
- ram_waddr_o  output  LOG_D  table write address
- ram_wdata_o  output  WIDTH  table write data
- ram_re_o  output  1  table read enable
- ram_raddr_o  output  LOG_D  table read address
- ram_rdata_i  input  WIDTH  table read data, combinational from ram_raddr_o

## Operation
- States: SWEEP, RUN. Reset enters SWEEP with sweep counter 0 and round-robin pointer 0.
- Outputs in reset: all ready/valid/enable outputs 0, data/address/index outputs 0, busy_o 1.
- SWEEP:
  - ram_we_o=1, ram_waddr_o=counter, ram_wdata_o=0; counter increments each cycle.
  - After writing address D-1, go to RUN; the counter returns to 0.
  - lk_ready_o=0, upd_ready_o=0, ram_re_o=0, busy_o=1.
- RUN, update path:
  - upd_ready_o=1.
  - When upd_valid_i=1: ram_we_o=1 with upd_addr_i/upd_data_i.
- RUN, lookup path:
  - A round-robin arbiter grants one asserted lk_valid_i per cycle. Search starts at the pointer and wraps modulo R.
  - lk_ready_o has the grant bit set combinationally in the same cycle.
  - On a grant: ram_re_o=1 and ram_raddr_o=granted address. The pointer becomes granted index+1 (mod R).
  - With no request, the pointer holds.
- Response: registered ram_rdata_i together with the granted index.
- RUN with flush_i=1: the next state is SWEEP. In that cycle, updates and lookups are still accepted normally. Sweep writes start the following cycle.
- Reset asserted mid-sweep or mid-operation: return to SWEEP at counter 0; no pending response is delivered.

## Timing
- Sweep length: exactly D cycles. busy_o deasserts on the first RUN cycle, D cycles after reset release.
- Lookup latency: 1 cycle. A grant at edge n gives rsp_valid_o=1 during cycle n+1. Accepting one lookup every cycle gives back-to-back responses.
- A lookup accepted in the last RUN cycle before SWEEP still produces its response during the first SWEEP cycle.
- Update and lookup to different addresses in the same cycle: both proceed.
- Update and lookup to the same address in the same cycle: behaviour is set by the macro (see Configuration).
- Writes become visible to lookups issued the cycle after the write.

## Configuration
- TABLE_SCHED_BYPASS_EN defined: a same-cycle same-address update and granted lookup return upd_data_i on the response (write-through bypass).
- TABLE_SCHED_BYPASS_EN undefined: the response returns the pre-write table content (ram_rdata_i).
- Arbitration, latency and all other behaviour are identical in both builds.

## Test plan
- Reset release, R=4, D=16 -> 16 cycles of ram_we_o=1 at addresses 0..15 with data 0 and busy_o=1; no lk_ready_o/upd_ready_o; RUN and busy_o=0 on cycle 17.
- All four lk_valid_i held high with addresses 3,5,7,9 -> grants in order 0,1,2,3,0; rsp_idx_o the same sequence delayed 1 cycle; data matches table.
- Update addr 5 = 0xA5A5A5A5, then lookup addr 5 the next cycle -> rsp_data_o=0xA5A5A5A5.
- Same-cycle update addr 2 = 0x1234 and lookup addr 2 (old value 0) -> response 0x1234 with TABLE_SCHED_BYPASS_EN defined, 0 without it.
- flush_i pulsed while requester 1 is granted -> requester 1's response delivered in the first SWEEP cycle; 16 zero writes follow; a later lookup of any address returns 0.
- rstn asserted at sweep counter 7 -> outputs go to reset values; the sweep restarts at address 0 after release.

Source files
------------

// File: rtl/table_access_scheduler_if.sv
// Lookup, response and update channels between requesters and table_access_scheduler.
interface table_access_scheduler_if #(
   parameter int R     = 4,
   parameter int D     = 16,
   parameter int WIDTH = 32
);
   localparam int LOG_D = (D > 1) ? $clog2(D) : 1;
   localparam int LOG_R = (R > 1) ? $clog2(R) : 1;

   logic [R-1:0]       lk_valid_i;
   logic [R-1:0]       lk_ready_o;
   logic [R*LOG_D-1:0] lk_addr_i;
   logic               rsp_valid_o;
   logic [LOG_R-1:0]   rsp_idx_o;
   logic [WIDTH-1:0]   rsp_data_o;
   logic               upd_valid_i;
   logic               upd_ready_o;
   logic [LOG_D-1:0]   upd_addr_i;
   logic [WIDTH-1:0]   upd_data_i;

   modport master (
      output lk_valid_i, lk_addr_i, upd_valid_i, upd_addr_i, upd_data_i,
      input  lk_ready_o, rsp_valid_o, rsp_idx_o, rsp_data_o, upd_ready_o
   );

   modport slave (
      input  lk_valid_i, lk_addr_i, upd_valid_i, upd_addr_i, upd_data_i,
      output lk_ready_o, rsp_valid_o, rsp_idx_o, rsp_data_o, upd_ready_o
   );
endinterface

// File: rtl/table_access_scheduler.sv
// Shares a combinational-read lookup table between R round-robin requesters and one update port,
// zeroing the table after reset and on flush. Define TABLE_SCHED_BYPASS_EN for same-address write-through.
module table_access_scheduler #(
   parameter int R     = 4,
   parameter int D     = 16,
   parameter int WIDTH = 32,
   parameter int LOG_D = (D > 1) ? $clog2(D) : 1,
   parameter int LOG_R = (R > 1) ? $clog2(R) : 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   table_access_scheduler_if.slave tif,
   input  logic                   flush_i,
   output logic                   busy_o,
   output logic                   ram_we_o,
   output logic [LOG_D-1:0]       ram_waddr_o,
   output logic [WIDTH-1:0]       ram_wdata_o,
   output logic                   ram_re_o,
   output logic [LOG_D-1:0]       ram_raddr_o,
   input  logic [WIDTH-1:0]       ram_rdata_i
);

   typedef enum logic {SWEEP, RUN} state_t;

   state_t           state_q, state_d;
   logic [LOG_D-1:0] cnt_q, cnt_d;
   logic [LOG_R-1:0] ptr_q, ptr_d;

   logic             arb_vld;
   logic [LOG_R-1:0] arb_idx;
   logic [LOG_D-1:0] arb_addr;
   int unsigned      idx;

   logic             grant;
   logic             upd_fire;
   logic [WIDTH-1:0] rsp_data_d;

   logic             rsp_valid_q;
   logic [LOG_R-1:0] rsp_idx_q;
   logic [WIDTH-1:0] rsp_data_q;

   // First asserted request at or after the pointer, wrapping modulo R.
   always_comb begin
      arb_vld = 1'b0;
      arb_idx = '0;
      idx     = 0;
      for (int unsigned k = 0; k < R; k++) begin
         idx = (32'(ptr_q) + k) % R;
         if (!arb_vld && tif.lk_valid_i[idx[LOG_R-1:0]]) begin
            arb_vld = 1'b1;
            arb_idx = idx[LOG_R-1:0];
         end
      end
      arb_addr = tif.lk_addr_i[arb_idx*LOG_D +: LOG_D];
   end

   // Outputs are qualified with rstn so they hold their idle values while reset is asserted.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      ptr_d           = ptr_q;
      grant           = 1'b0;
      upd_fire        = 1'b0;
      busy_o          = 1'b1;
      ram_we_o        = 1'b0;
      ram_waddr_o     = '0;
      ram_wdata_o     = '0;
      ram_re_o        = 1'b0;
      ram_raddr_o     = '0;
      tif.lk_ready_o  = '0;
      tif.upd_ready_o = 1'b0;
      if (rstn) begin
         case (state_q)
            SWEEP: begin
               ram_we_o    = 1'b1;
               ram_waddr_o = cnt_q;
               cnt_d       = cnt_q + 1'b1;
               if (cnt_q == LOG_D'(D - 1)) begin
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               busy_o          = 1'b0;
               tif.upd_ready_o = 1'b1;
               upd_fire        = tif.upd_valid_i;
               if (upd_fire) begin
                  ram_we_o    = 1'b1;
                  ram_waddr_o = tif.upd_addr_i;
                  ram_wdata_o = tif.upd_data_i;
               end
               if (arb_vld) begin
                  grant                   = 1'b1;
                  tif.lk_ready_o[arb_idx] = 1'b1;
                  ram_re_o                = 1'b1;
                  ram_raddr_o             = arb_addr;
                  ptr_d = (arb_idx == LOG_R'(R - 1)) ? '0 : arb_idx + 1'b1;
               end
               if (flush_i) state_d = SWEEP;
            end
            default: state_d = SWEEP;
         endcase
      end
   end

   always_comb begin
`ifdef TABLE_SCHED_BYPASS_EN
      rsp_data_d = (upd_fire && (tif.upd_addr_i == arb_addr)) ? tif.upd_data_i : ram_rdata_i;
`else
      rsp_data_d = ram_rdata_i;
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= SWEEP;
         cnt_q       <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_idx_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= grant;
         if (grant) begin
            rsp_idx_q  <= arb_idx;
            rsp_data_q <= rsp_data_d;
         end
      end
   end

   assign tif.rsp_valid_o = rsp_valid_q;
   assign tif.rsp_idx_o   = rsp_idx_q;
   assign tif.rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_table_access_scheduler.sv
// Randomized bench for table_access_scheduler against a cycle-level behavioural model of the table.
module tb_table_access_scheduler;
   localparam int R     = 4;
   localparam int D     = 16;
   localparam int WIDTH = 32;
   localparam int LOG_D = 4;
   localparam int LOG_R = 2;
`ifdef TABLE_SCHED_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             flush;
   logic             busy, ram_we, ram_re;
   logic [LOG_D-1:0] ram_waddr, ram_raddr;
   logic [WIDTH-1:0] ram_wdata, ram_rdata;
   logic [WIDTH-1:0] mem [D];

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   table_access_scheduler_if #(.R(R), .D(D), .WIDTH(WIDTH)) bus ();

   table_access_scheduler #(.R(R), .D(D), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .tif         (bus),
      .flush_i     (flush),
      .busy_o      (busy),
      .ram_we_o    (ram_we),
      .ram_waddr_o (ram_waddr),
      .ram_wdata_o (ram_wdata),
      .ram_re_o    (ram_re),
      .ram_raddr_o (ram_raddr),
      .ram_rdata_i (ram_rdata)
   );

   // External table: combinational read, write on the clock edge.
   assign ram_rdata = mem[ram_raddr];
   always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;

   // Reference model state
   bit               m_sweep = 1'b1;
   int               m_cnt   = 0;
   int               m_ptr   = 0;
   logic [WIDTH-1:0] m_tab [D];
   bit               m_pend  = 1'b0;
   int               m_pidx  = 0;
   logic [WIDTH-1:0] m_pdata = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Check one cycle's outputs against the model, advance the model, move to the next negedge.
   task automatic cycle();
      int g;
      int a;
      int i;
      logic [R-1:0] exp_rdy;
      #1;
      if (!rstn) begin
         m_sweep = 1'b1; m_cnt = 0; m_ptr = 0; m_pend = 1'b0;
      end
      check("rsp_valid", bus.rsp_valid_o, m_pend);
      if (m_pend) begin
         check("rsp_idx", bus.rsp_idx_o, m_pidx);
         check("rsp_data", bus.rsp_data_o, m_pdata);
      end
      if (!rstn) begin
         check("rst_busy", busy, 1);
         check("rst_we", ram_we, 0);
         check("rst_re", ram_re, 0);
         check("rst_lk_ready", bus.lk_ready_o, 0);
         check("rst_upd_ready", bus.upd_ready_o, 0);
         check("rst_addr", {ram_waddr, ram_raddr}, 0);
         check("rst_wdata", ram_wdata, 0);
         check("rst_rsp", {bus.rsp_idx_o, bus.rsp_data_o}, 0);
      end else if (m_sweep) begin
         check("sw_busy", busy, 1);
         check("sw_lk_ready", bus.lk_ready_o, 0);
         check("sw_upd_ready", bus.upd_ready_o, 0);
         check("sw_re", ram_re, 0);
         check("sw_we", ram_we, 1);
         check("sw_waddr", ram_waddr, m_cnt);
         check("sw_wdata", ram_wdata, 0);
         m_tab[m_cnt] = '0;
         m_cnt++;
         if (m_cnt == D) begin
            m_sweep = 1'b0;
            m_cnt   = 0;
         end
         m_pend = 1'b0;
      end else begin
         check("run_busy", busy, 0);
         check("run_upd_ready", bus.upd_ready_o, 1);
         check("run_we", ram_we, bus.upd_valid_i);
         if (bus.upd_valid_i) begin
            check("upd_waddr", ram_waddr, bus.upd_addr_i);
            check("upd_wdata", ram_wdata, bus.upd_data_i);
         end
         g = -1;
         for (int k = 0; k < R; k++) begin
            i = (m_ptr + k) % R;
            if (g < 0 && bus.lk_valid_i[i]) g = i;
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         check("lk_ready", bus.lk_ready_o, exp_rdy);
         check("run_re", ram_re, g >= 0);
         if (g >= 0) begin
            a = int'(bus.lk_addr_i[g*LOG_D +: LOG_D]);
            check("raddr", ram_raddr, a);
            m_pend  = 1'b1;
            m_pidx  = g;
            m_pdata = (BYPASS && bus.upd_valid_i && int'(bus.upd_addr_i) == a) ?
                      bus.upd_data_i : m_tab[a];
            m_ptr   = (g + 1) % R;
         end else begin
            m_pend = 1'b0;
         end
         if (bus.upd_valid_i) m_tab[bus.upd_addr_i] = bus.upd_data_i;
         if (flush) m_sweep = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic [R-1:0] v, input logic [R*LOG_D-1:0] a,
                        input logic uv, input logic [LOG_D-1:0] ua, input logic [WIDTH-1:0] ud,
                        input logic fl);
      bus.lk_valid_i  = v;
      bus.lk_addr_i   = a;
      bus.upd_valid_i = uv;
      bus.upd_addr_i  = ua;
      bus.upd_data_i  = ud;
      flush           = fl;
   endtask

   task automatic idle(input int n);
      drive('0, '0, 1'b0, '0, '0, 1'b0);
      for (int c = 0; c < n; c++) cycle();
   endtask

   initial begin
      bit reached;
      drive('0, '0, 1'b0, '0, '0, 1'b0);
      cycle();
      cycle();
      rstn = 1'b1;
      idle(18);

      // Preload 3,5,7,9 then all four requesters contend
      drive('0, '0, 1'b1, 4'd3, 32'h0000_0333, 1'b0); cycle();
      drive('0, '0, 1'b1, 4'd5, 32'h0000_0555, 1'b0); cycle();
      drive('0, '0, 1'b1, 4'd7, 32'h0000_0777, 1'b0); cycle();
      drive('0, '0, 1'b1, 4'd9, 32'h0000_0999, 1'b0); cycle();
      drive(4'b1111, {4'd9, 4'd7, 4'd5, 4'd3}, 1'b0, '0, '0, 1'b0);
      for (int c = 0; c < 5; c++) cycle();
      idle(1);

      // Write then read back next cycle
      drive('0, '0, 1'b1, 4'd5, 32'hA5A5_A5A5, 1'b0); cycle();
      drive(4'b0001, {12'd0, 4'd5}, 1'b0, '0, '0, 1'b0); cycle();
      idle(1);

      // Same-cycle update and lookup of address 2
      drive(4'b0100, {4'd0, 4'd2, 8'd0}, 1'b1, 4'd2, 32'h0000_1234, 1'b0); cycle();
      idle(1);
      drive(4'b0100, {4'd0, 4'd2, 8'd0}, 1'b0, '0, '0, 1'b0); cycle();

      // Flush while requester 1 is granted, with rejected traffic during the sweep
      drive(4'b0010, {8'd0, 4'd9, 4'd0}, 1'b0, '0, '0, 1'b1); cycle();
      for (int c = 0; c < D + 2; c++) begin
         drive(R'($urandom), (R*LOG_D)'($urandom), 1'($urandom), LOG_D'($urandom), $urandom, 1'b0);
         cycle();
      end
      for (int c = 0; c < 6; c++) begin
         drive(R'($urandom), (R*LOG_D)'($urandom), 1'b0, '0, '0, 1'b0);
         cycle();
      end

      // Randomized traffic with occasional flushes and forced address collisions
      for (int c = 0; c < 600; c++) begin
         drive(R'($urandom), (R*LOG_D)'($urandom), 1'($urandom), LOG_D'($urandom), $urandom,
               $urandom_range(0, 49) == 0);
         if ($urandom_range(0, 3) == 0)
            bus.upd_addr_i = bus.lk_addr_i[$urandom_range(0, R-1)*LOG_D +: LOG_D];
         cycle();
      end

      // Reset at sweep counter 7
      idle(D + 2);
      drive('0, '0, 1'b0, '0, '0, 1'b1); cycle();
      drive('0, '0, 1'b0, '0, '0, 1'b0);
      reached = 1'b0;
      for (int c = 0; c < 40 && !reached; c++) begin
         if (m_sweep && m_cnt == 7) reached = 1'b1;
         else cycle();
      end
      check("sweep_cnt7_reached", reached, 1);
      rstn = 1'b0;
      cycle();
      cycle();
      rstn = 1'b1;
      idle(D + 3);
      drive(4'b1010, {4'd7, 4'd0, 4'd3, 4'd0}, 1'b0, '0, '0, 1'b0);
      for (int c = 0; c < 3; c++) cycle();
      idle(1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
